// File: rtl/fc_pkg.sv
// Shared types for the fully connected layer and its parameter loader.
package fc_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        LOAD_B,
        DONE
    } fc_load_state_t;

    // Index width for a count of n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_index_counter.sv
// Write index counter with a run-time terminal value; wraps to zero on the terminal beat.
module fc_index_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [Width-1:0] i_term,
    output logic [Width-1:0] o_count,
    output logic             o_last
);

    logic [Width-1:0] r_count;

    assign o_count = r_count;
    assign o_last  = (r_count == i_term);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_last ? '0 : r_count + Width'(1);
        end
    end

endmodule

// File: rtl/fc_param_loader.sv
// Streams weight then bias words into the FC layer's parameter arrays; raises loaded when full.
module fc_param_loader
    import fc_pkg::*;
#(
    parameter int unsigned numNodesIn  = 5,
    parameter int unsigned numNodesOut = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] inData,
    input  logic              inValid,
    output logic              inReady,
    output logic [WORD_W-1:0] weights [numNodesIn*numNodesOut],
    output logic [WORD_W-1:0] biases  [numNodesOut],
    output logic              loaded
);

    localparam int unsigned NumW = numNodesIn * numNodesOut;
    localparam int unsigned CntW = idx_width(NumW);
    localparam int unsigned BW   = idx_width(numNodesOut);

    localparam logic [CntW-1:0] TermW = CntW'(NumW - 1);
    localparam logic [CntW-1:0] TermB = CntW'(numNodesOut - 1);

    fc_load_state_t r_state;
    fc_load_state_t w_state_d;

    logic            r_in_ready;
    logic            r_loaded;
    logic            w_clear;
    logic            w_loading;
    logic            w_beat;
    logic            w_last;
    logic [CntW-1:0] w_term;
    logic [CntW-1:0] w_idx;
    logic [BW-1:0]   w_bidx;
    word_t           r_weights [NumW];
    word_t           r_biases  [numNodesOut];

    // start takes priority over a data beat, so an aborted beat is never written.
    assign w_loading = (r_state == LOAD_W) || (r_state == LOAD_B);
    assign w_beat    = w_loading && inValid && !start;
    assign w_term    = (r_state == LOAD_B) ? TermB : TermW;
    assign w_bidx    = w_idx[BW-1:0];

    fc_index_counter #(
        .Width (CntW)
    ) u_idx (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_inc   (w_beat),
        .i_term  (w_term),
        .o_count (w_idx),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_d = r_state;
        w_clear   = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_d = LOAD_W;
                    w_clear   = 1'b1;
                end
            end
            LOAD_W: begin
                if (start) begin
                    w_clear = 1'b1;
                end else if (w_beat && w_last) begin
                    w_state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (start) begin
                    w_state_d = LOAD_W;
                    w_clear   = 1'b1;
                end else if (w_beat && w_last) begin
                    w_state_d = DONE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state: no input-to-output path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_loaded   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= (w_state_d == LOAD_W) || (w_state_d == LOAD_B);
            r_loaded   <= (w_state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NumW); i++) begin
                r_weights[i] <= '0;
            end
            for (int i = 0; i < int'(numNodesOut); i++) begin
                r_biases[i] <= '0;
            end
        end else if (w_beat) begin
            if (r_state == LOAD_W) begin
                r_weights[w_idx] <= inData;
            end else begin
                r_biases[w_bidx] <= inData;
            end
        end
    end

    assign inReady = r_in_ready;
    assign loaded  = r_loaded;
    assign weights = r_weights;
    assign biases  = r_biases;

endmodule

// File: tb/tb_fc_param_loader.sv
// Self-checking bench for fc_param_loader: directed scenarios plus random traffic vs a word-count model.
module tb_fc_param_loader;

    localparam int N     = 5;
    localparam int M     = 3;
    localparam int NM    = N * M;
    localparam int TOTAL = NM + M;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        inValid;
    logic [15:0] inData;
    logic        inReady;
    logic        loaded;
    logic [15:0] weights [NM];
    logic [15:0] biases  [M];

    always #5 clk = ~clk;

    fc_param_loader #(
        .numNodesIn  (N),
        .numNodesOut (M)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .inData  (inData),
        .inValid (inValid),
        .inReady (inReady),
        .weights (weights),
        .biases  (biases),
        .loaded  (loaded)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: number of words accepted since the last start, and the expected arrays.
    bit          m_started;
    int          m_cnt;
    logic [15:0] m_w [NM];
    logic [15:0] m_b [M];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit m_ready();
        return m_started && (m_cnt < TOTAL);
    endfunction

    function automatic bit m_loaded();
        return m_started && (m_cnt == TOTAL);
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_cnt     = 0;
        for (int i = 0; i < NM; i++) m_w[i] = '0;
        for (int i = 0; i < M; i++) m_b[i] = '0;
    endtask

    task automatic model_step(input bit s, input bit v, input logic [15:0] d);
        if (s) begin
            m_started = 1'b1;
            m_cnt     = 0;
        end else if (m_ready() && v) begin
            if (m_cnt < NM) m_w[m_cnt] = d;
            else m_b[m_cnt - NM] = d;
            m_cnt++;
        end
    endtask

    task automatic check_all(input string where);
        check_eq({where, " inReady"}, 32'(inReady), 32'(m_ready()));
        check_eq({where, " loaded"}, 32'(loaded), 32'(m_loaded()));
        for (int i = 0; i < NM; i++)
            check_eq($sformatf("%s weights[%0d]", where, i), 32'(weights[i]), 32'(m_w[i]));
        for (int i = 0; i < M; i++)
            check_eq($sformatf("%s biases[%0d]", where, i), 32'(biases[i]), 32'(m_b[i]));
    endtask

    // Called just after a rising edge: drive, check at the falling edge, then advance the model.
    task automatic cycle(input string where, input bit s, input bit v, input logic [15:0] d);
        start   = s;
        inValid = v;
        inData  = d;
        @(negedge clk);
        check_all(where);
        @(posedge clk);
        model_step(s, v, d);
        #1;
    endtask

    task automatic async_reset(input string where);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(where);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic full_load(input string where, input logic [15:0] base);
        cycle(where, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < TOTAL; i++) cycle(where, 1'b0, 1'b1, base + 16'(i));
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;
        repeat (3) cycle("idle", 1'b0, 1'b1, 16'h1234);

        // Back-to-back stream 1..18; loaded must be seen in the 19th cycle after the start edge.
        full_load("stream", 16'd1);
        @(negedge clk);
        check_eq("loaded_at_k19", 32'(loaded), 32'd1);
        check_eq("w0_after_stream", 32'(weights[0]), 32'd1);
        check_eq("b2_after_stream", 32'(biases[M-1]), 32'd18);
        @(posedge clk);
        #1;

        // Same words with inValid toggling.
        begin
            int w = 1;
            cycle("toggle", 1'b1, 1'b0, 16'h0);
            for (int i = 0; i < 2 * TOTAL; i++) begin
                cycle("toggle", 1'b0, (i % 2) == 0, 16'(w));
                if ((i % 2) == 0) w++;
            end
        end
        cycle("toggle_done", 1'b0, 1'b0, 16'h0);

        // Abort after 7 weights, then reload 100..117.
        cycle("restart", 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 7; i++) cycle("restart", 1'b0, 1'b1, 16'(50 + i));
        cycle("abort", 1'b1, 1'b1, 16'hDEAD);
        for (int i = 0; i < TOTAL; i++) cycle("reload", 1'b0, 1'b1, 16'(100 + i));

        // Traffic in DONE must be dropped.
        repeat (10) cycle("done_hold", 1'b0, 1'b1, 16'hFFFF);

        // Asynchronous reset in the middle of a load.
        cycle("pre_rst", 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) cycle("pre_rst", 1'b0, 1'b1, 16'(200 + i));
        async_reset("async_rst");
        cycle("post_rst", 1'b0, 1'b0, 16'h0);
        full_load("post_rst", 16'd300);
        cycle("post_rst_done", 1'b0, 1'b0, 16'h0);

        // Random traffic: occasional starts, sparse valids, rare resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rand_rst");
            end else begin
                cycle("rand", $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                      16'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fc_param_loader.md
# fc_param_loader

Parameter loader for the fully connected layer: accepts a serial stream of 16-bit words over a valid/ready handshake and fills the weight and bias register arrays that the FC layer reads in parallel. It sits upstream of the FC layer. Its `loaded` output drives the layer's `enable`, so the layer only starts once every parameter word is in place.

## Interface
- `numNodesIn`, default 5: inputs per output node (row length).
- `numNodesOut`, default 3: number of output nodes.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs immediately.
- `start`  in  1  level sampled each edge; begins or restarts a load.
- `inData`  in  16  parameter word (fixed-point, passed through unmodified).
- `inValid`  in  1  `inData` is valid this cycle.
- `inReady`  out  1  loader accepts a word this cycle.
- `weights`  out  16 × (numNodesIn·numNodesOut)  unpacked array, indices 0..N·M-1.
- `biases`  out  16 × numNodesOut  unpacked array, indices 0..M-1.
- `loaded`  out  1  arrays complete and stable; connect to the layer's `enable`.

## Operation
- States: IDLE, LOAD_W, LOAD_B, DONE.
- IDLE: `inReady`=0, `loaded`=0. `start`=1 → LOAD_W, index counter=0.
- LOAD_W: `inReady`=1. Each edge with `inValid`=1 writes `weights[idx]`=`inData` and increments idx.
  - On the word written at idx=N·M-1 → LOAD_B, idx=0.
- Weight order is row-major by output node: `weights[o·numNodesIn + i]` multiplies input i for output o. This matches the layer's consumption order.
- LOAD_B: same handshake, writing `biases[idx]`. On the word at idx=M-1 → DONE.
- DONE: `loaded`=1, `inReady`=0. Arrays hold their values indefinitely.
  - `start`=1 → LOAD_W, idx=0, and `loaded` drops.
- `start`=1 in LOAD_W/LOAD_B aborts the load: the current beat is not written, state → LOAD_W, idx=0.
- Arrays are never bulk-cleared except by reset. A restarted load overwrites entries in place.
- `inValid`=0 stalls with no change. `inValid` while `inReady`=0 is ignored and the word is dropped.
- Counter width is `$clog2(N·M)` bits minimum, and the counter never exceeds its terminal index.

## Timing
- Reset (async assert): state=IDLE, idx=0, `inReady`=0, `loaded`=0, all `weights`/`biases`=0.
- Deassertion takes effect at the next edge.
- `start` sampled at edge k → `inReady`=1 during cycle k+1. The first word can be accepted at edge k+1.
- One word per cycle max. With `inValid` held high, the last bias is accepted at edge k+N·M+M, and `loaded`=1 during the following cycle.
- `inReady` and `loaded` are registered outputs derived from state; there is no combinational path from inputs.
- `loaded` is never high while any array entry is being written.
- Reset asserted mid-load returns to IDLE with all arrays zeroed.

## Structure
- Shared package `fc_pkg`:
  - `WORD_W`=16
  - `fc_load_state_t` enum {IDLE, LOAD_W, LOAD_B, DONE}
  - a `word_t` typedef
- The FC layer's interface also uses these.
- One sub-module is natural: `fc_index_counter` (parameterised terminal count, clear, increment, `last` flag). It is instantiated once and reused for both phases.

## Test plan
- Reset, then N=5, M=3. Pulse `start`, stream words 1..18 with `inValid` high → `weights[0..14]`=1..15, `biases[0..2]`=16..18. `loaded` rises exactly 19 cycles after `start` edge +1.
- Same stream with `inValid` toggling 1,0,1,0 → identical final arrays. `inReady` stays 1 throughout LOAD_W/LOAD_B. Completion takes 36 data cycles.
- Assert `start` after 7 weights, then stream 100..117 → `weights[0..14]`=100..114, `biases`=115..117. No stale values remain.
- In DONE, drive `inValid`=1, `inData`=0xFFFF for 10 cycles → arrays unchanged, `loaded` stays 1.
- Assert `reset` low after 10 words → `inReady`=0 and `loaded`=0 asynchronously. All arrays read 0 next sample. After release, a full load completes normally.
- Connect to the FC layer with inputs all 1.0 (0x0100 Q8.8), a weight row of 1.0, and biases 0 → each output equals numNodesIn·1.0. `finished` asserts only after `loaded`.
